sd_wb_xfer: RTL and testbench

//  Wishbone-side responder for the SD block manager's ext_read/ext_write handshakes.

---
 rtl/sd_wb_xfer.sv | 209 ++++++++++++++++++++
 tb/tb_sd_wb_xfer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_wb_xfer.sv
// Moves one 512-byte sector between Wishbone and the SD manager's ext BRAM ports (read: WB->BRAM, write: BRAM->WB).
// Reads hold stb across words and take 1 cycle/word at zero wait; writes take 3 cycles/word minimum; wb_ack stalls both.
module sd_wb_xfer #(
  parameter logic [31:0] WB_BASE = 32'h0000_0000,
  parameter int          WORDS   = 128
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        ext_read_act,
  input  logic [31:0] ext_read_addr,
  output logic        ext_read_go,
  input  logic        ext_read_stop,
  input  logic        ext_write_act,
  input  logic [31:0] ext_write_addr,
  output logic        ext_write_done,
  output logic [6:0]  bram_rd_ext_addr,
  output logic        bram_rd_ext_wren,
  output logic [31:0] bram_rd_ext_data,
  output logic [6:0]  bram_wr_ext_addr,
  input  logic [31:0] bram_wr_ext_q,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic        xfer_err
);

  localparam logic [6:0] LAST_IDX = 7'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_GO, RD_END, WR_ADDR, WR_LOAD, WR_REQ, WR_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [31:0] adr_q, adr_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic        rd_wren_q, rd_wren_d;
  logic [6:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        go_q, go_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    adr_d     = adr_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    dat_o_d   = dat_o_q;
    rd_wren_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    go_d      = go_q;
    done_d    = done_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (!go_q && !done_q) begin
          if (ext_read_act) begin
            state_d = RD_REQ;
            idx_d   = 7'd0;
            adr_d   = WB_BASE + (ext_read_addr << 9);
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b0;
          end else if (ext_write_act) begin
            state_d = WR_ADDR;
            idx_d   = 7'd0;
            adr_d   = WB_BASE + (ext_write_addr << 9);
          end
        end
      end

      // err outranks a simultaneous ack; the handshake still completes so the manager never hangs
      RD_REQ: begin
        if (wb_err) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = RD_GO;
        end else if (wb_ack) begin
          rd_wren_d = 1'b1;
          rd_addr_d = idx_q;
          rd_data_d = wb_dat_i;
          if (idx_q == LAST_IDX) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = RD_GO;
          end else begin
            idx_d = idx_q + 7'd1;
            adr_d = adr_q + 32'd4;
          end
        end
      end

      RD_GO: begin
        if (!go_q) begin
          go_d = 1'b1;
        end else if (ext_read_stop) begin
          go_d    = 1'b0;
          state_d = RD_END;
        end
      end

      RD_END: begin
        if (!ext_read_act && !ext_read_stop) begin
          state_d = IDLE;
          idx_d   = 7'd0;
        end
      end

      WR_ADDR: state_d = WR_LOAD;

      WR_LOAD: begin
        dat_o_d = bram_wr_ext_q;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        state_d = WR_REQ;
      end

      WR_REQ: begin
        if (wb_err || (wb_ack && idx_q == LAST_IDX)) begin
          err_d   = err_q | wb_err;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = WR_DONE;
        end else if (wb_ack) begin
          stb_d   = 1'b0;
          idx_d   = idx_q + 7'd1;
          adr_d   = adr_q + 32'd4;
          state_d = WR_ADDR;
        end
      end

      WR_DONE: begin
        if (!ext_write_act) begin
          done_d  = 1'b0;
          state_d = IDLE;
          idx_d   = 7'd0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 7'd0;
      adr_q     <= 32'd0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      dat_o_q   <= 32'd0;
      rd_wren_q <= 1'b0;
      rd_addr_q <= 7'd0;
      rd_data_q <= 32'd0;
      go_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      adr_q     <= adr_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      dat_o_q   <= dat_o_d;
      rd_wren_q <= rd_wren_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      go_q      <= go_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // write-BRAM address is presented straight from idx so q lines up with WR_LOAD
  assign bram_wr_ext_addr = idx_q;
  assign bram_rd_ext_addr = rd_addr_q;
  assign bram_rd_ext_wren = rd_wren_q;
  assign bram_rd_ext_data = rd_data_q;
  assign wb_cyc           = cyc_q;
  assign wb_stb           = stb_q;
  assign wb_we            = we_q;
  assign wb_adr           = adr_q;
  assign wb_sel           = stb_q ? 4'hF : 4'h0;
  assign wb_dat_o         = dat_o_q;
  assign ext_read_go      = go_q;
  assign ext_write_done   = done_q;
  assign xfer_err         = err_q;

endmodule

// File: tb/tb_sd_wb_xfer.sv
// Bench for sd_wb_xfer: Wishbone slave with wait states/err injection, write-BRAM model, and a scoreboard.
module tb_sd_wb_xfer;

  logic        clk_50;
  logic        reset = 1'b1;
  logic        ext_read_act = 1'b0, ext_read_stop = 1'b0;
  logic [31:0] ext_read_addr = 32'd0;
  logic        ext_write_act = 1'b0;
  logic [31:0] ext_write_addr = 32'd0;
  logic        ext_read_go, ext_write_done;
  logic [6:0]  bram_rd_ext_addr, bram_wr_ext_addr;
  logic        bram_rd_ext_wren;
  logic [31:0] bram_rd_ext_data;
  logic [31:0] bram_wr_ext_q = 32'd0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_ack = 1'b0, wb_err = 1'b0;
  logic        xfer_err;

  sd_wb_xfer #(.WB_BASE(32'h0000_0000), .WORDS(128)) dut (
    .clk_50(clk_50), .reset(reset),
    .ext_read_act(ext_read_act), .ext_read_addr(ext_read_addr),
    .ext_read_go(ext_read_go), .ext_read_stop(ext_read_stop),
    .ext_write_act(ext_write_act), .ext_write_addr(ext_write_addr),
    .ext_write_done(ext_write_done),
    .bram_rd_ext_addr(bram_rd_ext_addr), .bram_rd_ext_wren(bram_rd_ext_wren),
    .bram_rd_ext_data(bram_rd_ext_data),
    .bram_wr_ext_addr(bram_wr_ext_addr), .bram_wr_ext_q(bram_wr_ext_q),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err), .xfer_err(xfer_err)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_txn_t;

  typedef struct packed {
    logic [6:0]  idx;
    logic [31:0] dat;
  } bram_txn_t;

  wb_txn_t     exp_wb[$], obs_wb[$];
  bram_txn_t   exp_bram[$], obs_bram[$];
  logic [31:0] wbram [128];

  int n_cmp = 0, n_fail = 0;
  int cyc_cnt = 0;
  int max_wait = 0, wait_left = 0, ack_words = 0, err_word = -1;
  int stb_drops = 0;
  int last_wren_cyc = 0, go_rise_cyc = 0;
  bit stb_prev = 1'b0, go_prev = 1'b0;
  logic go_after_stop, done_held, done_after;

  initial begin
    clk_50 = 1'b0;
    forever #5 clk_50 = ~clk_50;
  end

  initial forever @(posedge clk_50) cyc_cnt++;

  initial forever @(posedge clk_50) bram_wr_ext_q <= wbram[bram_wr_ext_addr];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Wishbone slave: answers at the negedge so the DUT samples ack/err on the next rising edge
  initial forever begin
    wb_txn_t t;
    @(negedge clk_50);
    if (stb_prev && !wb_ack && !wb_err && !wb_stb) stb_drops++;
    stb_prev = wb_stb;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat_i = 32'hDEAD_BEEF;
    if (wb_cyc && wb_stb) begin
      if (wait_left > 0) begin
        wait_left--;
      end else begin
        if (ack_words == err_word) wb_err = 1'b1;
        else wb_ack = 1'b1;
        wb_dat_i = mem_word(wb_adr);
        t.adr = wb_adr;
        t.we  = wb_we;
        t.dat = wb_we ? wb_dat_o : 32'd0;
        t.sel = wb_sel;
        obs_wb.push_back(t);
        ack_words++;
        wait_left = int'($urandom_range(max_wait, 0));
      end
    end
  end

  initial forever begin
    bram_txn_t b;
    @(negedge clk_50);
    if (bram_rd_ext_wren) begin
      b.idx = bram_rd_ext_addr;
      b.dat = bram_rd_ext_data;
      obs_bram.push_back(b);
      last_wren_cyc = cyc_cnt;
    end
    if (ext_read_go && !go_prev) go_rise_cyc = cyc_cnt;
    go_prev = ext_read_go;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_sb();
    exp_wb.delete(); obs_wb.delete(); exp_bram.delete(); obs_bram.delete();
    ack_words = 0;
    wait_left = 0;
  endtask

  task automatic push_read(input logic [31:0] sector, input int n_ok, input bit with_err);
    wb_txn_t t;
    bram_txn_t b;
    for (int i = 0; i < n_ok + (with_err ? 1 : 0); i++) begin
      t.adr = (sector << 9) + 32'(i * 4);
      t.we  = 1'b0;
      t.dat = 32'd0;
      t.sel = 4'hF;
      exp_wb.push_back(t);
      if (i < n_ok) begin
        b.idx = 7'(i);
        b.dat = mem_word(t.adr);
        exp_bram.push_back(b);
      end
    end
  endtask

  task automatic push_write(input logic [31:0] sector);
    wb_txn_t t;
    for (int i = 0; i < 128; i++) begin
      t.adr = (sector << 9) + 32'(i * 4);
      t.we  = 1'b1;
      t.dat = wbram[i];
      t.sel = 4'hF;
      exp_wb.push_back(t);
    end
  endtask

  task automatic wait_sig(input bit want_go, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk_50);
      if (want_go ? ext_read_go : ext_write_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_read(input logic [31:0] sector, output bit ok);
    @(negedge clk_50);
    ext_read_addr = sector;
    ext_read_act  = 1'b1;
    wait_sig(1'b1, ok);
    ext_read_stop = ok;
    @(negedge clk_50);
    go_after_stop = ext_read_go;
    ext_read_act  = 1'b0;
    ext_read_stop = 1'b0;
    repeat (2) @(negedge clk_50);
  endtask

  task automatic do_write(input logic [31:0] sector, output bit ok);
    @(negedge clk_50);
    ext_write_addr = sector;
    ext_write_act  = 1'b1;
    wait_sig(1'b0, ok);
    repeat (3) @(negedge clk_50);
    done_held = ext_write_done;
    ext_write_act = 1'b0;
    @(negedge clk_50);
    done_after = ext_write_done;
    repeat (2) @(negedge clk_50);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_50);
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_wb got %h want 0", {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o});
    end
    n_cmp++;
    if ({ext_read_go, ext_write_done, xfer_err, bram_rd_ext_wren, bram_rd_ext_addr,
         bram_rd_ext_data, bram_wr_ext_addr} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_hs got go=%b done=%b err=%b wren=%b want all 0",
               ext_read_go, ext_write_done, xfer_err, bram_rd_ext_wren);
    end
    reset = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic test_read_zero_wait();
    bit ok;
    wb_txn_t e, o;
    bram_txn_t eb, ob;
    max_wait = 0; err_word = -1;
    clear_sb();
    push_read(32'd5, 128, 1'b0);
    do_read(32'd5, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL t1_go_timeout got go=0 want go=1"); end
    while (exp_wb.size() > 0) begin
      e = exp_wb.pop_front();
      o = (obs_wb.size() > 0) ? obs_wb.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL t1_wb got %h want %h", o, e); end
    end
    while (exp_bram.size() > 0) begin
      eb = exp_bram.pop_front();
      ob = (obs_bram.size() > 0) ? obs_bram.pop_front() : '0;
      n_cmp++;
      if (ob !== eb) begin n_fail++; $display("FAIL t1_bram got %h want %h", ob, eb); end
    end
    n_cmp++;
    if (obs_wb.size() + obs_bram.size() != 0) begin
      n_fail++; $display("FAIL t1_extra got %0d extra txns want 0", obs_wb.size() + obs_bram.size());
    end
    n_cmp++;
    if (go_rise_cyc != last_wren_cyc + 1) begin
      n_fail++; $display("FAIL t1_go_rise got cycle %0d want %0d", go_rise_cyc, last_wren_cyc + 1);
    end
    n_cmp++;
    if (go_after_stop !== 1'b0) begin n_fail++; $display("FAIL t1_go_fall got %b want 0", go_after_stop); end
  endtask

  task automatic test_write_zero_wait();
    bit ok;
    wb_txn_t e, o;
    for (int i = 0; i < 128; i++) wbram[i] = 32'(i * 3);
    max_wait = 0; err_word = -1;
    clear_sb();
    push_write(32'h10);
    do_write(32'h10, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL t2_done_timeout got done=0 want done=1"); end
    while (exp_wb.size() > 0) begin
      e = exp_wb.pop_front();
      o = (obs_wb.size() > 0) ? obs_wb.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL t2_wb got %h want %h", o, e); end
    end
    n_cmp++;
    if (obs_wb.size() != 0) begin n_fail++; $display("FAIL t2_extra got %0d want 0", obs_wb.size()); end
    n_cmp++;
    if (done_held !== 1'b1) begin n_fail++; $display("FAIL t2_done_held got %b want 1", done_held); end
    n_cmp++;
    if (done_after !== 1'b0) begin n_fail++; $display("FAIL t2_done_fall got %b want 0", done_after); end
  endtask

  task automatic test_wait_states();
    bit ok_r, ok_w;
    int drops0;
    wb_txn_t e, o;
    bram_txn_t eb, ob;
    max_wait = 5; err_word = -1;
    clear_sb();
    drops0 = stb_drops;
    push_read(32'd5, 128, 1'b0);
    push_write(32'h10);
    do_read(32'd5, ok_r);
    do_write(32'h10, ok_w);
    n_cmp++;
    if (!(ok_r && ok_w)) begin n_fail++; $display("FAIL t3_timeout got rd=%b wr=%b want 1 1", ok_r, ok_w); end
    while (exp_wb.size() > 0) begin
      e = exp_wb.pop_front();
      o = (obs_wb.size() > 0) ? obs_wb.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL t3_wb got %h want %h", o, e); end
    end
    while (exp_bram.size() > 0) begin
      eb = exp_bram.pop_front();
      ob = (obs_bram.size() > 0) ? obs_bram.pop_front() : '0;
      n_cmp++;
      if (ob !== eb) begin n_fail++; $display("FAIL t3_bram got %h want %h", ob, eb); end
    end
    n_cmp++;
    if (stb_drops != drops0) begin n_fail++; $display("FAIL t3_stb_drop got %0d drops want 0", stb_drops - drops0); end
    max_wait = 0;
  endtask

  task automatic test_read_err();
    bit ok;
    wb_txn_t e, o;
    bram_txn_t eb, ob;
    max_wait = 0;
    clear_sb();
    err_word = 40;
    push_read(32'd9, 40, 1'b1);
    do_read(32'd9, ok);
    err_word = -1;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL t4_go_timeout got go=0 want go=1"); end
    n_cmp++;
    if (xfer_err !== 1'b1) begin n_fail++; $display("FAIL t4_xfer_err got %b want 1", xfer_err); end
    n_cmp++;
    if (obs_bram.size() != 40) begin n_fail++; $display("FAIL t4_bram_count got %0d want 40", obs_bram.size()); end
    while (exp_wb.size() > 0) begin
      e = exp_wb.pop_front();
      o = (obs_wb.size() > 0) ? obs_wb.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL t4_wb got %h want %h", o, e); end
    end
    while (exp_bram.size() > 0) begin
      eb = exp_bram.pop_front();
      ob = (obs_bram.size() > 0) ? obs_bram.pop_front() : '0;
      n_cmp++;
      if (ob !== eb) begin n_fail++; $display("FAIL t4_bram got %h want %h", ob, eb); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok_r, ok_w;
    wb_txn_t e, o;
    bram_txn_t eb, ob;
    max_wait = 2; err_word = -1;
    clear_sb();
    push_read(32'd7, 128, 1'b0);
    push_write(32'd3);
    @(negedge clk_50);
    ext_read_addr = 32'd7; ext_write_addr = 32'd3;
    ext_read_act = 1'b1; ext_write_act = 1'b1;
    wait_sig(1'b1, ok_r);
    ext_read_stop = 1'b1;
    @(negedge clk_50);
    ext_read_act = 1'b0; ext_read_stop = 1'b0;
    wait_sig(1'b0, ok_w);
    ext_write_act = 1'b0;
    repeat (3) @(negedge clk_50);
    n_cmp++;
    if (!(ok_r && ok_w)) begin n_fail++; $display("FAIL t5_timeout got rd=%b wr=%b want 1 1", ok_r, ok_w); end
    while (exp_wb.size() > 0) begin
      e = exp_wb.pop_front();
      o = (obs_wb.size() > 0) ? obs_wb.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL t5_order got %h want %h", o, e); end
    end
    while (exp_bram.size() > 0) begin
      eb = exp_bram.pop_front();
      ob = (obs_bram.size() > 0) ? obs_bram.pop_front() : '0;
      n_cmp++;
      if (ob !== eb) begin n_fail++; $display("FAIL t5_bram got %h want %h", ob, eb); end
    end
    max_wait = 0;
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    wb_txn_t e, o;
    max_wait = 0; err_word = -1;
    clear_sb();
    @(negedge clk_50);
    ext_write_addr = 32'h30;
    ext_write_act  = 1'b1;
    for (int c = 0; c < 2000 && ack_words < 60; c++) @(negedge clk_50);
    reset = 1'b1;
    ext_write_act = 1'b0;
    @(negedge clk_50);
    n_cmp++;
    if ({wb_cyc, wb_stb, ext_write_done} !== 3'b000) begin
      n_fail++; $display("FAIL t6_reset_drop got cyc/stb/done=%b want 000", {wb_cyc, wb_stb, ext_write_done});
    end
    reset = 1'b0;
    @(negedge clk_50);
    n_cmp++;
    if (xfer_err !== 1'b0) begin n_fail++; $display("FAIL t6_err_clear got %b want 0", xfer_err); end
    clear_sb();
    push_write(32'h21);
    do_write(32'h21, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL t6_done_timeout got done=0 want done=1"); end
    n_cmp++;
    if (obs_wb.size() == 0 || obs_wb[0].adr !== 32'h0000_4200) begin
      n_fail++; $display("FAIL t6_restart_adr got %h want 00004200", (obs_wb.size() > 0) ? obs_wb[0].adr : 32'hX);
    end
    while (exp_wb.size() > 0) begin
      e = exp_wb.pop_front();
      o = (obs_wb.size() > 0) ? obs_wb.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL t6_wb got %h want %h", o, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) wbram[i] = 32'd0;
    test_reset();
    test_read_zero_wait();
    test_write_zero_wait();
    test_wait_states();
    test_read_err();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
